// File: rtl/led_matrix_scan.sv
// Multiplexed bicolour LED matrix scanner: per-row dwell, anti-ghost blanking,
// duty-based brightness and a double-buffered frame load with valid/ready handshake.
module led_matrix_scan #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int DWELL          = 1000,
    parameter int BLANK          = 16,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [3:0]           brightness,
    input  logic [ROWS*COLS-1:0] frame_r,
    input  logic [ROWS*COLS-1:0] frame_g,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 frame_start,
    output logic [COLS-1:0]      col_r,
    output logic [COLS-1:0]      col_g,
    output logic [ROWS-1:0]      row
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC);
    localparam int RW   = $clog2(ROWS);
    localparam int PW   = CW + 5;
    localparam logic [ROWS-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [RW-1:0]         r_row_idx;
    logic [CW:0]           r_on;
    logic [ROWS*COLS-1:0]  r_act_r, r_act_g, r_shd_r, r_shd_g;
    logic                  r_ready;
    logic                  r_frame_start;
    logic [ROWS-1:0]       r_row;
    logic [COLS-1:0]       r_col_r, r_col_g;

    state_t                w_state_n;
    logic [CW-1:0]         w_cnt_n;
    logic [RW-1:0]         w_row_n;
    logic                  w_frame_chk;
    logic                  w_drive_entry;
    logic [PW-1:0]         w_prod;
    logic [CW:0]           w_on_new;
    logic [CW:0]           w_on;
    logic [ROWS-1:0]       w_sel;
    logic [COLS-1:0]       w_slice_r, w_slice_g;

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_row_n       = r_row_idx;
        w_frame_chk   = 1'b0;
        w_drive_entry = 1'b0;
        if (!enable) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_row_n   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_n   = S_BLANK;
                    w_cnt_n     = '0;
                    w_row_n     = '0;
                    w_frame_chk = 1'b1;
                end
                S_BLANK: begin
                    if (r_cnt == CW'(BLANK - 1)) begin
                        w_state_n     = S_DRIVE;
                        w_cnt_n       = '0;
                        w_drive_entry = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == CW'(DWELL - 1)) begin
                        w_state_n = S_BLANK;
                        w_cnt_n   = '0;
                        if (r_row_idx == RW'(ROWS - 1)) begin
                            w_row_n     = '0;
                            w_frame_chk = 1'b1;
                        end else begin
                            w_row_n = r_row_idx + RW'(1);
                        end
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // On-time is latched at DRIVE entry; the entry cycle itself uses the fresh value.
    always_comb begin
        w_prod   = (PW'(brightness) + PW'(1)) * PW'(DWELL);
        w_on_new = (CW+1)'(w_prod >> 4);
        w_on     = w_drive_entry ? w_on_new : r_on;
    end

    always_comb begin
        w_sel     = '0;
        w_slice_r = '0;
        w_slice_g = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (w_row_n == RW'(i)) begin
                w_sel[i]  = 1'b1;
                w_slice_r = r_act_r[i*COLS +: COLS];
                w_slice_g = r_act_g[i*COLS +: COLS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_row_idx <= '0;
            r_on      <= '0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_row_idx <= w_row_n;
            if (w_drive_entry) r_on <= w_on_new;
        end
    end

    // Swap and load are mutually exclusive: a swap needs a pending frame, a load needs none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_r <= '0;
            r_act_g <= '0;
            r_shd_r <= '0;
            r_shd_g <= '0;
            r_ready <= 1'b1;
        end else if (w_frame_chk && !r_ready) begin
            r_act_r <= r_shd_r;
            r_act_g <= r_shd_g;
            r_ready <= 1'b1;
        end else if (load_valid && r_ready) begin
            r_shd_r <= frame_r;
            r_shd_g <= frame_g;
            r_ready <= 1'b0;
        end
    end

    // Outputs are registered from next-state values so they track the FSM without lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_row         <= ROW_OFF;
            r_col_r       <= '0;
            r_col_g       <= '0;
        end else begin
            r_frame_start <= w_frame_chk;
            if (w_state_n == S_DRIVE) begin
                r_row <= (ROW_ACTIVE_LOW != 0) ? ~w_sel : w_sel;
                if ({1'b0, w_cnt_n} < w_on) begin
                    r_col_r <= w_slice_r;
                    r_col_g <= w_slice_g;
                end else begin
                    r_col_r <= '0;
                    r_col_g <= '0;
                end
            end else begin
                r_row   <= ROW_OFF;
                r_col_r <= '0;
                r_col_g <= '0;
            end
        end
    end

    assign load_ready  = r_ready;
    assign frame_start = r_frame_start;
    assign col_r       = r_col_r;
    assign col_g       = r_col_g;
    assign row         = r_row;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan (4x4, DWELL=16, BLANK=2, active-low rows).
module tb_led_matrix_scan;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  brightness;
    logic [15:0] frame_r;
    logic [15:0] frame_g;
    logic        load_valid;
    logic        load_ready;
    logic        frame_start;
    logic [3:0]  col_r;
    logic [3:0]  col_g;
    logic [3:0]  row;

    int n_total;
    int n_pass;

    led_matrix_scan #(
        .ROWS(4), .COLS(4), .DWELL(16), .BLANK(2), .ROW_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
        .frame_r(frame_r), .frame_g(frame_g), .load_valid(load_valid),
        .load_ready(load_ready), .frame_start(frame_start),
        .col_r(col_r), .col_g(col_g), .row(row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // Checks one full frame starting at the sample where frame_start is high.
    task automatic run_frame(input logic [15:0] fr, input logic [15:0] fg, input int on,
                             input int load_row, input logic [15:0] lr, input logic [15:0] lg);
        logic [3:0] exp_row;
        logic [3:0] exp_r;
        logic [3:0] exp_g;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (!(i == 0 && b == 0)) tick();
                chk("blank", {19'd0, frame_start, row, col_r, col_g},
                    {19'd0, (i == 0 && b == 0), 4'hF, 8'h00});
            end
            exp_row = ~(4'b0001 << i);
            for (int d = 0; d < 16; d++) begin
                tick();
                exp_r = (d < on) ? fr[i*4 +: 4] : 4'h0;
                exp_g = (d < on) ? fg[i*4 +: 4] : 4'h0;
                chk("drive", {19'd0, frame_start, row, col_r, col_g},
                    {19'd0, 1'b0, exp_row, exp_r, exp_g});
                if (i == load_row) begin
                    if (d == 0) begin
                        frame_r    = lr;
                        frame_g    = lg;
                        load_valid = 1'b1;
                    end else if (d == 1) begin
                        chk("ready_drop_mid", {31'd0, load_ready}, 32'd0);
                        frame_r    = 16'h5555;
                        frame_g    = 16'h5555;
                    end else if (d == 2) begin
                        load_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        brightness = 4'd15;
        frame_r    = '0;
        frame_g    = '0;
        load_valid = 1'b0;
        tick();
        tick();
        chk("reset", {18'd0, load_ready, frame_start, row, col_r, col_g},
            {18'd0, 1'b1, 1'b0, 4'hF, 8'h00});
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle", {19'd0, frame_start, row, col_r, col_g}, {19'd0, 1'b0, 4'hF, 8'h00});
        end

        // Frame A loaded while idle, then scan at full brightness.
        frame_r    = 16'h8421;
        frame_g    = 16'h1248;
        load_valid = 1'b1;
        tick();
        chk("ready_drop", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
        enable     = 1'b1;
        tick();
        chk("ready_after_swap", {31'd0, load_ready}, 32'd1);
        run_frame(16'h8421, 16'h1248, 16, -1, 16'h0, 16'h0);

        brightness = 4'd3;
        tick();
        run_frame(16'h8421, 16'h1248, 4, -1, 16'h0, 16'h0);

        brightness = 4'd0;
        tick();
        run_frame(16'h8421, 16'h1248, 1, -1, 16'h0, 16'h0);

        // Frame B loaded in row 2; a decoy load while pending must be ignored.
        brightness = 4'd15;
        tick();
        run_frame(16'h8421, 16'h1248, 16, 2, 16'hFFFF, 16'h0000);
        tick();
        chk("ready_after_swap_b", {31'd0, load_ready}, 32'd1);
        run_frame(16'hFFFF, 16'h0000, 16, -1, 16'h0, 16'h0);

        // Disable mid-DRIVE of row 1, load C while idle, re-enable.
        tick();
        chk("fs_b2", {31'd0, frame_start}, 32'd1);
        for (int k = 0; k < 25; k++) tick();
        chk("row1_mid", {19'd0, frame_start, row, col_r, col_g}, {19'd0, 1'b0, 4'hD, 4'hF, 4'h0});
        enable = 1'b0;
        tick();
        chk("disable_blank", {19'd0, frame_start, row, col_r, col_g}, {19'd0, 1'b0, 4'hF, 8'h00});
        frame_r    = 16'h00F0;
        frame_g    = 16'h0F00;
        load_valid = 1'b1;
        tick();
        chk("load_while_idle", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("disabled", {19'd0, frame_start, row, col_r, col_g}, {19'd0, 1'b0, 4'hF, 8'h00});
        end
        enable = 1'b1;
        tick();
        run_frame(16'h00F0, 16'h0F00, 16, -1, 16'h0, 16'h0);

        // Asynchronous reset mid-dwell discards a pending frame D.
        tick();
        chk("fs_c2", {31'd0, frame_start}, 32'd1);
        frame_r    = 16'h3333;
        frame_g    = 16'h3333;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("ready_drop_d", {31'd0, load_ready}, 32'd0);
        for (int k = 0; k < 4; k++) tick();
        chk("row0_mid", {19'd0, frame_start, row, col_r, col_g}, {19'd0, 1'b0, 4'hE, 8'h00});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {18'd0, load_ready, frame_start, row, col_r, col_g},
            {18'd0, 1'b1, 1'b0, 4'hF, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(16'h0000, 16'h0000, 16, -1, 16'h0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Parametrised multiplexed scanner for bicolour (red/green) LED dot matrices. It supersedes the fixed 8x8 one-row-per-clock scanner. It adds configurable geometry, a per-row dwell time, anti-ghost blanking, global brightness by on-time duty, and a double-buffered frame load with a valid/ready handshake. It sits between the display-content logic (temperature/mode graphics) and the matrix driver pins.

## Interface
Parameters:
- ROWS, 8, number of scanned rows (2..16)
- COLS, 8, columns per row per colour (1..16)
- DWELL, 1000, clk cycles a row is driven (>=16)
- BLANK, 16, clk cycles all outputs are off between rows (>=1)
- ROW_ACTIVE_LOW, 1, 1: selected row bit is 0; 0: selected row bit is 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = scan; 0 = blank display and park the scanner at row 0
- brightness  in  4  global duty, 0 = 1/16 on-time, 15 = full dwell
- frame_r  in  ROWS*COLS  red frame; row i uses bits [(i+1)*COLS-1 -: COLS]
- frame_g  in  ROWS*COLS  green frame, same layout
- load_valid  in  1  frame_r/frame_g hold a new frame
- load_ready  out  1  shadow buffer is free
- frame_start  out  1  one-cycle pulse at the start of each frame
- col_r  out  COLS  red column drive, active high
- col_g  out  COLS  green column drive, active high
- row  out  ROWS  one-hot row select, polarity set by ROW_ACTIVE_LOW

## Operation
- Two buffers per colour:
  - shadow: written by the handshake.
  - active: displayed.
  - A pending flag marks an unconsumed shadow frame.
- Handshake: load_ready = !pending. When load_valid && load_ready, capture frame_r/frame_g into shadow and set pending. load_ready falls on the next cycle. load_valid without load_ready is ignored; data is not required to be held.
- Swap: on entering BLANK for row 0, if pending, active <= shadow and pending clears in the same cycle. The frame is never torn mid-scan.
- FSM states:
  - IDLE: entered at reset, or whenever enable=0.
  - BLANK: cycle counter 0..BLANK-1.
  - DRIVE: cycle counter 0..DWELL-1.
- Transitions:
  - IDLE -> BLANK(row 0) when enable=1.
  - BLANK -> DRIVE at counter BLANK-1.
  - DRIVE -> BLANK(row+1) at counter DWELL-1; the row index wraps ROWS-1 -> 0.
  - Any state -> IDLE when enable=0, with row index and counter cleared.
- Outputs in IDLE and BLANK: row all inactive, col_r = col_g = 0.
- Outputs in DRIVE:
  - row has bit `row_idx` active.
  - Columns show the active slice for row_idx while counter < ON, where ON = ((brightness+1)*DWELL)>>4. Columns are 0 for the rest of the dwell.
  - brightness is sampled at DRIVE entry and held for that row.
- frame_start pulses in the cycle the swap check occurs (BLANK entry of row 0), whether or not a swap happens.
- Arithmetic: counter width is clog2(max(DWELL,BLANK)). ON is computed at full width before the shift, with no overflow. brightness=15 gives ON = DWELL.

## Timing
- All outputs are registered. Each output reflects the state of the previous clock edge.
- Row period = BLANK + DWELL cycles. Frame period = ROWS*(BLANK+DWELL) cycles.
- First DRIVE cycle of row 0 comes BLANK+1 cycles after enable is first sampled high from IDLE.
- Reset values: row = all inactive (all ones if ROW_ACTIVE_LOW, else zeros), col_r = col_g = 0, load_ready = 1, frame_start = 0. Active, shadow and pending are all cleared, so the display is blank.
- Reset mid-frame: outputs go to reset values asynchronously and any pending frame is discarded.
- enable falling mid-DRIVE: outputs are blank on the next edge. A pending frame is retained and swapped at the next row-0 entry.
- A load accepted during row 0 BLANK, after the swap check, is displayed from the next frame.

## Test plan
Bench uses ROWS=4, COLS=4, DWELL=16, BLANK=2, ROW_ACTIVE_LOW=1.
- Reset, enable=0 -> row=4'b1111, cols=0, load_ready=1, frame_start never pulses.
- Load frame_r=16'h8421, brightness=15, enable=1 -> load_ready drops one cycle after the handshake. Frame_start pulses. Then, per row i, row=~(1<<i) for 16 cycles with col_r=4'h1,2,4,8 for i=0..3, separated by 2 blank cycles. The period repeats every 72 cycles.
- brightness=3 -> ON = 4: columns are driven for 4 cycles and zero for 12 cycles of each dwell. brightness=0 -> 1 cycle.
- Load frame B (16'hFFFF) during row 2 -> rows 2–3 still show frame A. Frame B appears at the next row 0. load_ready rises one cycle after the swap.
- Assert load_valid while pending=1 with different data -> it is ignored, and the displayed frame is the first loaded one.
- Deassert enable mid-DRIVE of row 1, re-enable after 5 cycles -> blank within 1 cycle. Scan restarts at row 0 after 2 blank cycles. Assert rst_n=0 asynchronously mid-dwell -> outputs take reset values immediately.
